gray_window_3x3: RTL and testbench
==================================

Name: gray_window_3x3

Overview:
- Sits directly downstream of rgb_to_grayscale and upstream of the Sobel gradient stage.
- Accepts the raster-order grayscale pixel stream (grayscale_o/done_o) and buffers two previous image lines.
- Emits a registered 3x3 pixel neighbourhood for every interior pixel, plus centre coordinates and an end-of-frame pulse.

Parameters:
- IMG_WIDTH, 640, pixels per line; must be >= 3.
- IMG_HEIGHT, 480, lines per frame; must be >= 3.
- DATA_W, 8, bits per grayscale pixel.
- COORD_W, 16, width of the coordinate outputs; must hold IMG_WIDTH-1 and IMG_HEIGHT-1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pix_i  in  DATA_W  grayscale pixel; connects to grayscale_o.
- valid_i  in  1  pixel qualifier, one pixel per high cycle; connects to done_o.
- window_o  out  9*DATA_W  3x3 neighbourhood; slice k = window_o[DATA_W*k +: DATA_W], k = 3*row + col.
- valid_o  out  1  window_o, x_o and y_o are valid this cycle.
- x_o  out  COORD_W  column of the window centre.
- y_o  out  COORD_W  row of the window centre.
- frame_done_o  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset: window_o, valid_o, x_o, y_o, frame_done_o all 0; col and row counters 0.
  - Line-buffer and shift-register contents are not cleared; gating makes them irrelevant.
- Counters:
  - col and row track the position of the pixel being accepted (valid_i=1).
  - col wraps IMG_WIDTH-1 -> 0 and increments row.
  - row wraps IMG_HEIGHT-1 -> 0 when col also wraps. This is the frame end.
- Line buffers:
  - lb0 holds line row-1; lb1 holds line row-2; each has depth IMG_WIDTH.
  - On an accept at col c, read lb0[c] and lb1[c] first (read-before-write in the same cycle).
  - Then write lb1[c] <= old lb0[c] and lb0[c] <= pix_i.
- Window shift:
  - On accept, the 3-column register shifts left by one column.
  - The new right column is {lb1[c], lb0[c], pix_i}, top to bottom.
  - It is not cleared at line start; output gating covers this.
- Window packing:
  - row 0 is the oldest line and col 0 is the oldest column.
  - k=0 is pixel (r-2, c-2); k=8 is pixel (r, c), the newest pixel.
- Output timing (latency 1 cycle):
  - In the cycle after accepting pixel (r, c) with r >= 2 and c >= 2: valid_o=1, x_o=c-1, y_o=r-1.
  - Otherwise valid_o=0; window_o, x_o, y_o hold their last values.
- Border pixels (row 0, row H-1, col 0, col W-1) never produce a window.
  - Windows per frame = (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- Bubbles: valid_i=0 freezes counters, buffers and the window register; valid_o=0 in the following cycle. Arbitrary gaps are legal, including within a line.
- frame_done_o:
  - 1 in the cycle after accepting pixel (H-1, W-1), coincident with the final valid_o.
  - 0 at all other times.
  - The next pixel accepted is treated as (0, 0) of a new frame; back-to-back frames need no idle cycle.
- Reset mid-frame: rst overrides valid_i. The next accepted pixel is (0, 0), and no window is emitted until row 2, col 2 of the new frame.
- No backpressure: the downstream stage must accept every valid_o pulse.

Test Plan:
- IMG_WIDTH=8, IMG_HEIGHT=6, pix = row*16+col, continuous valid_i -> first valid_o one cycle after pixel (2,2) is accepted; window = 00,01,02,10,11,12,20,21,22 (k=0..8); x_o=1, y_o=1.
- Same frame -> exactly 24 valid_o pulses. Last window has x_o=6, y_o=4, k=8 = 0x57. frame_done_o is high in the same cycle as that last valid_o, and is the only frame_done_o pulse.
- Same frame with valid_i toggled 1,0,1,0... -> identical window/x/y sequence as the continuous run; valid_o never high in consecutive cycles.
- Two back-to-back frames, frame 2 pix = 0x80 + row*16+col -> frame 2's first window has k=0 = 0x80 and k=8 = 0xA2; no window mixes frame-1 and frame-2 rows at a frame-2 centre; 48 valid_o pulses in total.
- rst asserted for 1 cycle after pixel (3,5), then a fresh frame is streamed -> valid_o=0 and frame_done_o=0 during reset and until pixel (2,2) of the new frame; the first window equals the first-scenario values.
- Line transition check: the window at x_o=6, y_o=1 is followed by x_o=1, y_o=2 with no window centred at col 0 or col 7 in between.

Source files
------------

// File: rtl/gray_window_3x3.sv
// 3x3 sliding neighbourhood over a raster grayscale stream: two line buffers
// plus a 3-column shift register, emitting one registered window per interior pixel.
module gray_window_3x3 #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DATA_W     = 8,
    parameter int COORD_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     pix_i,
    input  logic                  valid_i,
    output logic [9*DATA_W-1:0]   window_o,
    output logic                  valid_o,
    output logic [COORD_W-1:0]    x_o,
    output logic [COORD_W-1:0]    y_o,
    output logic                  frame_done_o
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0]      COL_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0]      ROW_LAST  = RW'(IMG_HEIGHT - 1);
    localparam logic [COORD_W-1:0] COORD_ONE = COORD_W'(1);

    logic [CW-1:0] col_reg;
    logic [RW-1:0] row_reg;
    logic          col_last;
    logic          row_last;
    logic          accept;
    logic          emit;
    logic          frame_end;

    assign accept    = valid_i;
    assign col_last  = (col_reg == COL_LAST);
    assign row_last  = (row_reg == ROW_LAST);
    assign emit      = accept && (row_reg >= RW'(2)) && (col_reg >= CW'(2));
    assign frame_end = accept && col_last && row_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (accept) begin
            if (col_last) begin
                col_reg <= '0;
                row_reg <= row_last ? '0 : row_reg + RW'(1);
            end else begin
                col_reg <= col_reg + CW'(1);
            end
        end
    end

    // Line buffers: lb0 holds line row-1, lb1 holds line row-2. Reads are
    // combinational so the old contents feed the window in the same accept cycle.
    logic [DATA_W-1:0] lb0_mem [IMG_WIDTH];
    logic [DATA_W-1:0] lb1_mem [IMG_WIDTH];
    logic [DATA_W-1:0] lb0_rd;
    logic [DATA_W-1:0] lb1_rd;

    assign lb0_rd = lb0_mem[col_reg];
    assign lb1_rd = lb1_mem[col_reg];

    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            lb1_mem[col_reg] <= lb0_rd;
            lb0_mem[col_reg] <= pix_i;
        end
    end

    // Window register, index k = 3*row + col; column 2 takes the new column.
    logic [DATA_W-1:0] col_in   [3];
    logic [DATA_W-1:0] win_reg  [9];
    logic [DATA_W-1:0] win_next [9];
    logic [9*DATA_W-1:0] win_next_flat;

    assign col_in[0] = lb1_rd;
    assign col_in[1] = lb0_rd;
    assign col_in[2] = pix_i;

    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_win
            if (gi % 3 == 2) begin : g_new_col
                assign win_next[gi] = col_in[gi / 3];
            end else begin : g_shift
                assign win_next[gi] = win_reg[gi + 1];
            end

            assign win_next_flat[DATA_W*gi +: DATA_W] = win_next[gi];

            always_ff @(posedge clk) begin
                if (!rst && accept) begin
                    win_reg[gi] <= win_next[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            window_o     <= '0;
            valid_o      <= 1'b0;
            x_o          <= '0;
            y_o          <= '0;
            frame_done_o <= 1'b0;
        end else begin
            valid_o      <= emit;
            frame_done_o <= frame_end;
            if (emit) begin
                window_o <= win_next_flat;
                x_o      <= COORD_W'(col_reg) - COORD_ONE;
                y_o      <= COORD_W'(row_reg) - COORD_ONE;
            end
        end
    end

endmodule

// File: tb/tb_gray_window_3x3.sv
// Directed bench for gray_window_3x3 on an 8x6 image with pix = base + row*16 + col.
module tb_gray_window_3x3;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 8;
    localparam int CWD = 16;
    localparam int NWIN = (W - 2) * (H - 2);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [DW-1:0]   pix_i = '0;
    logic            valid_i = 1'b0;
    logic [9*DW-1:0] window_o;
    logic            valid_o;
    logic [CWD-1:0]  x_o;
    logic [CWD-1:0]  y_o;
    logic            frame_done_o;

    gray_window_3x3 #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .DATA_W    (DW),
        .COORD_W   (CWD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_i       (pix_i),
        .valid_i     (valid_i),
        .window_o    (window_o),
        .valid_o     (valid_o),
        .x_o         (x_o),
        .y_o         (y_o),
        .frame_done_o(frame_done_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Event log of every valid_o cycle, sampled on the falling edge.
    logic [9*DW-1:0] ev_win    [128];
    logic [CWD-1:0]  ev_x      [128];
    logic [CWD-1:0]  ev_y      [128];
    logic            ev_fd     [128];
    logic            ev_consec [128];
    int              n_ev = 0;
    int              fd_count = 0;
    logic            prev_valid = 1'b0;

    always @(negedge clk) begin
        if (valid_o === 1'b1 && n_ev < 128) begin
            ev_win[n_ev]    = window_o;
            ev_x[n_ev]      = x_o;
            ev_y[n_ev]      = y_o;
            ev_fd[n_ev]     = frame_done_o;
            ev_consec[n_ev] = prev_valid;
            n_ev++;
        end
        if (frame_done_o === 1'b1) fd_count++;
        prev_valid = valid_o;
    end

    function automatic logic [9*DW-1:0] exp_win(input int base, input int x, input int y);
        logic [9*DW-1:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[DW*(3*i+j) +: DW] = DW'(base + (y - 1 + i) * 16 + (x - 1 + j));
        return w;
    endfunction

    task automatic clear_log();
        @(posedge clk); #1;
        n_ev = 0;
        fd_count = 0;
    endtask

    task automatic drive_pix(input int base, input int r, input int c, input bit gap);
        @(posedge clk); #1;
        pix_i   = DW'(base + r * 16 + c);
        valid_i = 1'b1;
        if (gap) begin
            @(posedge clk); #1;
            valid_i = 1'b0;
            pix_i   = 8'hEE;
        end
    endtask

    task automatic stream_frame(input int base, input bit gap);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                drive_pix(base, r, c, gap);
    endtask

    task automatic drain();
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid_i = 1'b1;
        pix_i = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_cmp++;
        if (frame_done_o !== 1'b0) begin n_bad++; $display("FAIL reset_fd: got %b want 0", frame_done_o); end
        n_cmp++;
        if (window_o !== '0 || x_o !== '0 || y_o !== '0) begin
            n_bad++;
            $display("FAIL reset_data: win=%h x=%0d y=%0d want all 0", window_o, x_o, y_o);
        end
        valid_i = 1'b0;
        rst = 1'b0;
        $display("test_reset: outputs after reset win=%h x=%0d y=%0d", window_o, x_o, y_o);
    endtask

    task automatic test_continuous();
        clear_log();
        stream_frame(0, 1'b0);
        drain();
        n_cmp++;
        if (n_ev !== NWIN) begin n_bad++; $display("FAIL cont_count: got %0d want %0d", n_ev, NWIN); end
        for (int e = 0; e < NWIN && e < n_ev; e++) begin
            n_cmp++;
            if (ev_win[e] !== exp_win(0, 1 + e % 6, 1 + e / 6) || ev_x[e] !== CWD'(1 + e % 6)
                || ev_y[e] !== CWD'(1 + e / 6) || ev_fd[e] !== (e == NWIN - 1)) begin
                n_bad++;
                $display("FAIL cont_win[%0d]: got win=%h x=%0d y=%0d fd=%b want win=%h x=%0d y=%0d fd=%b",
                         e, ev_win[e], ev_x[e], ev_y[e], ev_fd[e],
                         exp_win(0, 1 + e % 6, 1 + e / 6), 1 + e % 6, 1 + e / 6, e == NWIN - 1);
            end
        end
        n_cmp++;
        if (fd_count !== 1) begin n_bad++; $display("FAIL cont_fd_count: got %0d want 1", fd_count); end
        $display("test_continuous: %0d windows, first win=%h, frame_done pulses=%0d",
                 n_ev, ev_win[0], fd_count);
    endtask

    task automatic test_toggle();
        clear_log();
        stream_frame(0, 1'b1);
        drain();
        n_cmp++;
        if (n_ev !== NWIN) begin n_bad++; $display("FAIL tog_count: got %0d want %0d", n_ev, NWIN); end
        for (int e = 0; e < NWIN && e < n_ev; e++) begin
            n_cmp++;
            if (ev_win[e] !== exp_win(0, 1 + e % 6, 1 + e / 6) || ev_x[e] !== CWD'(1 + e % 6)
                || ev_y[e] !== CWD'(1 + e / 6) || ev_consec[e] !== 1'b0) begin
                n_bad++;
                $display("FAIL tog_win[%0d]: got win=%h x=%0d y=%0d consec=%b want win=%h x=%0d y=%0d consec=0",
                         e, ev_win[e], ev_x[e], ev_y[e], ev_consec[e],
                         exp_win(0, 1 + e % 6, 1 + e / 6), 1 + e % 6, 1 + e / 6);
            end
        end
        n_cmp++;
        if (fd_count !== 1) begin n_bad++; $display("FAIL tog_fd_count: got %0d want 1", fd_count); end
        $display("test_toggle: %0d windows with bubbles", n_ev);
    endtask

    task automatic test_back_to_back();
        int base;
        clear_log();
        stream_frame(0, 1'b0);
        stream_frame(8'h80, 1'b0);
        drain();
        n_cmp++;
        if (n_ev !== 2 * NWIN) begin n_bad++; $display("FAIL b2b_count: got %0d want %0d", n_ev, 2 * NWIN); end
        for (int e = 0; e < 2 * NWIN && e < n_ev; e++) begin
            base = (e < NWIN) ? 0 : 8'h80;
            n_cmp++;
            if (ev_win[e] !== exp_win(base, 1 + (e % NWIN) % 6, 1 + (e % NWIN) / 6)
                || ev_fd[e] !== ((e % NWIN) == NWIN - 1)) begin
                n_bad++;
                $display("FAIL b2b_win[%0d]: got win=%h fd=%b want win=%h fd=%b", e, ev_win[e], ev_fd[e],
                         exp_win(base, 1 + (e % NWIN) % 6, 1 + (e % NWIN) / 6), (e % NWIN) == NWIN - 1);
            end
        end
        n_cmp++;
        if (n_ev > NWIN && (ev_win[NWIN][7:0] !== 8'h80 || ev_win[NWIN][71:64] !== 8'hA2)) begin
            n_bad++;
            $display("FAIL b2b_first2: got k0=%h k8=%h want k0=80 k8=a2", ev_win[NWIN][7:0], ev_win[NWIN][71:64]);
        end
        n_cmp++;
        if (fd_count !== 2) begin n_bad++; $display("FAIL b2b_fd_count: got %0d want 2", fd_count); end
        $display("test_back_to_back: %0d windows, frame_done pulses=%0d", n_ev, fd_count);
    endtask

    task automatic test_reset_mid_frame();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < W; c++)
                if (r < 3 || c <= 5) drive_pix(8'h40, r, c, 1'b0);
        @(posedge clk); #1;
        valid_i = 1'b1;
        pix_i   = 8'h77;
        rst     = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        valid_i = 1'b0;
        n_ev = 0;
        fd_count = 0;
        n_cmp++;
        if (valid_o !== 1'b0 || frame_done_o !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_out: got valid=%b fd=%b want 0 0", valid_o, frame_done_o);
        end
        stream_frame(0, 1'b0);
        drain();
        n_cmp++;
        if (n_ev !== NWIN) begin n_bad++; $display("FAIL rstmid_count: got %0d want %0d", n_ev, NWIN); end
        n_cmp++;
        if (n_ev > 0 && (ev_win[0] !== exp_win(0, 1, 1) || ev_x[0] !== CWD'(1) || ev_y[0] !== CWD'(1))) begin
            n_bad++;
            $display("FAIL rstmid_first: got win=%h x=%0d y=%0d want win=%h x=1 y=1",
                     ev_win[0], ev_x[0], ev_y[0], exp_win(0, 1, 1));
        end
        n_cmp++;
        if (fd_count !== 1) begin n_bad++; $display("FAIL rstmid_fd_count: got %0d want 1", fd_count); end
        $display("test_reset_mid_frame: %0d windows after reset, first win=%h", n_ev, ev_win[0]);
    endtask

    task automatic test_line_transition();
        clear_log();
        stream_frame(0, 1'b0);
        drain();
        n_cmp++;
        if (ev_x[5] !== CWD'(6) || ev_y[5] !== CWD'(1) || ev_x[6] !== CWD'(1) || ev_y[6] !== CWD'(2)) begin
            n_bad++;
            $display("FAIL line_trans: got (%0d,%0d)->(%0d,%0d) want (6,1)->(1,2)",
                     ev_x[5], ev_y[5], ev_x[6], ev_y[6]);
        end
        n_cmp++;
        if (ev_win[6] !== exp_win(0, 1, 2)) begin
            n_bad++;
            $display("FAIL line_trans_win: got %h want %h", ev_win[6], exp_win(0, 1, 2));
        end
        for (int e = 0; e < n_ev && e < 128; e++) begin
            n_cmp++;
            if (ev_x[e] == CWD'(0) || ev_x[e] == CWD'(W - 1) || ev_y[e] == CWD'(0) || ev_y[e] == CWD'(H - 1)) begin
                n_bad++;
                $display("FAIL line_border[%0d]: got x=%0d y=%0d want interior centre", e, ev_x[e], ev_y[e]);
            end
        end
        $display("test_line_transition: (%0d,%0d) -> (%0d,%0d)", ev_x[5], ev_y[5], ev_x[6], ev_y[6]);
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_toggle();
        test_back_to_back();
        test_reset_mid_frame();
        test_line_transition();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
